// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash pin set between NUM_REQ requesters.
// Optional per-grant hold watchdog compiled in with `define SPI_ARB_WDOG_EN.
module spi_flash_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned CS_GAP      = 4,
  parameter int unsigned WDOG_CYCLES = 48000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  input  logic [NUM_REQ-1:0] req_cs_b,
  input  logic [NUM_REQ-1:0] req_sck,
  input  logic [NUM_REQ-1:0] req_mosi,
  output logic               req_miso,
  output logic               spi_cs_b,
  output logic               spi_sck,
  output logic               spi_mosi,
  input  logic               spi_miso,
  output logic               wdog_timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWNED = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   rr_next;
  logic               sel_valid;
  logic [7:0]         gap_cnt;
  logic [NUM_REQ-1:0] eligible;
  logic               owner_req;
  logic               wdog_fire;
  logic               release_now;

  assign owner_req   = req[owner_idx];
  assign release_now = (state == ST_OWNED) && (!owner_req || wdog_fire);

`ifdef SPI_ARB_WDOG_EN
  logic [31:0]        hold_cnt;
  logic [NUM_REQ-1:0] wdog_mask;
  logic               wdog_pulse;

  assign wdog_fire    = (state == ST_OWNED) && owner_req &&
                        (hold_cnt == 32'(WDOG_CYCLES - 1));
  assign eligible     = req & ~wdog_mask;
  assign wdog_timeout = wdog_pulse;

  // A timed-out owner stays masked until its req has been seen low once.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      wdog_mask  <= '0;
      wdog_pulse <= 1'b0;
    end else begin
      wdog_pulse <= wdog_fire;
      if (state == ST_IDLE && sel_valid)
        hold_cnt <= '0;
      else if (state == ST_OWNED)
        hold_cnt <= hold_cnt + 32'd1;
      wdog_mask <= wdog_mask & req;
      if (wdog_fire)
        wdog_mask[owner_idx] <= 1'b1;
    end
  end
`else
  assign wdog_fire    = 1'b0;
  assign eligible     = req;
  assign wdog_timeout = 1'b0;
`endif

  // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!sel_valid && eligible[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign rr_next = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      owner_idx <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            grant          <= '0;
            grant[sel_idx] <= 1'b1;
            owner_idx      <= sel_idx;
            rr_ptr         <= rr_next;
            state          <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (release_now) begin
            grant   <= '0;
            gap_cnt <= 8'(CS_GAP - 1);
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0)
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt - 8'd1;
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign req_miso = spi_miso;

  always_comb begin
    spi_cs_b = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    if (state == ST_OWNED && grant[owner_idx]) begin
      spi_cs_b = req_cs_b[owner_idx];
      spi_sck  = req_sck[owner_idx];
      spi_mosi = req_mosi[owner_idx];
    end
  end

  a_params_ok: assert property (@(posedge clk)
    NUM_REQ >= 2 && NUM_REQ <= 8 && CS_GAP >= 1 && CS_GAP <= 255 && WDOG_CYCLES >= 1);
  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant));
  a_cs_idle_no_grant: assert property (@(posedge clk) (grant == '0) |-> spi_cs_b);

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed self-checking bench for spi_flash_arbiter (NUM_REQ=2, CS_GAP=4).
module tb_spi_flash_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned CS_GAP  = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic [NUM_REQ-1:0] req_cs_b;
  logic [NUM_REQ-1:0] req_sck;
  logic [NUM_REQ-1:0] req_mosi;
  logic               req_miso;
  logic               spi_cs_b;
  logic               spi_sck;
  logic               spi_mosi;
  logic               spi_miso;
  logic               wdog_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_flash_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .CS_GAP     (CS_GAP),
    .WDOG_CYCLES(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .busy        (busy),
    .req_cs_b    (req_cs_b),
    .req_sck     (req_sck),
    .req_mosi    (req_mosi),
    .req_miso    (req_miso),
    .spi_cs_b    (spi_cs_b),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .wdog_timeout(wdog_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int max, output int n);
    n = 0;
    while (grant == '0 && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int owner;
    logic seen_pulse;

    reset    = 1'b1;
    req      = '0;
    req_cs_b = '1;
    req_sck  = '0;
    req_mosi = '0;
    spi_miso = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // {grant, busy, cs_b, sck, mosi, wdog}
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_state", 32'({grant, busy, spi_cs_b, spi_sck, spi_mosi, wdog_timeout}),
            32'b00_0_1_0_0_0);
    end

    spi_miso = 1'b1; #1;
    check("miso_hi", 32'(req_miso), 32'd1);
    spi_miso = 1'b0; #1;
    check("miso_lo", 32'(req_miso), 32'd0);

    // Single requester
    req = 2'b01;
    tick();
    check("single_grant", 32'(grant), 32'b01);
    check("single_busy", 32'(busy), 32'd1);
    check("single_cs_before", 32'(spi_cs_b), 32'd1);
    req_cs_b = 2'b10; req_sck = 2'b01; req_mosi = 2'b01; #1;
    check("single_pins_a", 32'({spi_cs_b, spi_sck, spi_mosi}), 32'b011);
    req_sck = 2'b10; req_mosi = 2'b10; #1;
    check("single_pins_b", 32'({spi_cs_b, spi_sck, spi_mosi}), 32'b000);
    req_cs_b = 2'b01; #1;
    check("single_pins_c", 32'(spi_cs_b), 32'd1);
    req_cs_b = 2'b10; req_sck = 2'b01; req_mosi = 2'b01;
    repeat (30) tick();
    check("single_hold", 32'(grant), 32'b01);

    // Early release while the owner still drives cs_b low and sck high
    req = 2'b00;
    tick();
    check("early_grant", 32'(grant), 32'd0);
    check("early_pins", 32'({spi_cs_b, spi_sck, spi_mosi}), 32'b100);
    check("early_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_pins", 32'({spi_cs_b, spi_sck, spi_mosi}), 32'b100);
      check("gap_busy", 32'(busy), 32'd1);
    end
    tick();
    check("gap_done_busy", 32'(busy), 32'd0);
    req_cs_b = '1; req_sck = '0; req_mosi = '0;

    // Simultaneous requests from reset
    reset = 1'b1;
    req   = 2'b11;
    tick();
    check("sim_reset_grant", 32'(grant), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("sim_first", 32'(grant), 32'b01);
    owner = 0;
    for (int r = 0; r < 3; r++) begin
      repeat (20) tick();
      check("sim_hold", 32'(grant), 32'(1) << owner);
      req[owner] = 1'b0;
      tick();
      check("sim_release", 32'(grant), 32'd0);
      req[owner] = 1'b1;
      wait_grant(20, n);
      check("sim_gap_len", 32'(n), 32'(CS_GAP + 1));
      check("sim_order", 32'(grant), 32'(1) << (1 - owner));
      owner = 1 - owner;
    end

    // Reset mid-transaction with owner 1 driving cs_b low
    req_cs_b = 2'b01; #1;
    check("rst_cs_before", 32'(spi_cs_b), 32'd0);
    reset = 1'b1;
    req   = 2'b10;
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_cs", 32'(spi_cs_b), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_regrant", 32'(grant), 32'b10);
    check("rst_cs_after", 32'(spi_cs_b), 32'd0);

    req = 2'b00; req_cs_b = '1;
    repeat (6) tick();
    check("quiet_busy", 32'(busy), 32'd0);

`ifdef SPI_ARB_WDOG_EN
    req = 2'b01;
    tick();
    check("wd_grant", 32'(grant), 32'b01);
    n = 0;
    while (!wdog_timeout && n < 300) begin
      tick();
      n++;
    end
    check("wd_hold_len", 32'(n), 32'd100);
    check("wd_release", 32'(grant), 32'd0);
    req[1] = 1'b1;
    tick();
    check("wd_pulse_end", 32'(wdog_timeout), 32'd0);
    wait_grant(20, n);
    check("wd_gap_len", 32'(n), 32'(CS_GAP));
    check("wd_next_owner", 32'(grant), 32'b10);
    req[1] = 1'b0;
    repeat (16) tick();
    check("wd_masked_grant", 32'(grant), 32'd0);
    check("wd_masked_busy", 32'(busy), 32'd0);
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    tick();
    check("wd_unmasked", 32'(grant), 32'b01);
`else
    req = 2'b01;
    tick();
    check("hold_grant", 32'(grant), 32'b01);
    seen_pulse = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      seen_pulse = seen_pulse | wdog_timeout;
    end
    check("hold_forever", 32'(grant), 32'b01);
    check("hold_no_wdog", 32'(seen_pulse), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
